// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Two-port arbiter in front of a 16-bit asynchronous SRAM. Requester r0 is
//   the data cache: it reads a 64-bit line or writes a 32-bit word. Requester
//   r1 is instruction fetch and only reads 64-bit lines. Requests are taken
//   only while idle. Ties go round-robin, and r0 wins the first tie after
//   reset. Every SRAM beat holds its address for WAIT_CYCLES+1 cycles.
//
//   Configuration macro: SRAM_ARB_IFETCH_PORT_EN
//     defined   -> r1 port and round-robin arbitration are active
//     undefined -> r1 ignored, r1_ready/r1_rdata stay 0, owner stays 0
//
//   Ports
//     clk, rst                      clock, synchronous active-high reset
//     r0_req/we/addr/wdata          data-cache request (byte address)
//     r0_rdata, r0_ready            data-cache line, one-cycle completion pulse
//     r1_req/addr                   instruction-fetch request (byte address)
//     r1_rdata, r1_ready            fetch line, one-cycle completion pulse
//     busy, owner                   FSM not idle, current/last grant (1 = r1)
//     SRAM_*                        SRAM pins; CE/OE/UB/LB tied active
module sram_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic [63:0] r0_rdata,
  output logic        r0_ready,
  input  logic        r1_req,
  input  logic [31:0] r1_addr,
  output logic [63:0] r1_rdata,
  output logic        r1_ready,
  output logic        busy,
  output logic        owner,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t         state;
  logic           prefer;     // requester that wins the next tie
  logic           is_write;
  logic [1:0]     beat;
  logic [CW-1:0]  cyc;        // cycle within the current beat
  logic [47:0]    line_buf;   // halfwords already captured, lowest first
  logic [15:0]    wdata_hi;
  logic [15:0]    dq_out;
  logic           dq_oe;

  logic           gnt_valid;
  logic           gnt_id;
  logic [31:0]    sel_addr;
  logic           last_beat;
  logic           unused_bits;

  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;

  // Grant selection among the requests visible this cycle.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
`ifdef SRAM_ARB_IFETCH_PORT_EN
    gnt_valid = r0_req | r1_req;
    if (r0_req && r1_req) begin
      gnt_id = prefer;
    end else if (r1_req) begin
      gnt_id = 1'b1;
    end else begin
      gnt_id = 1'b0;
    end
`else
    gnt_valid = r0_req;
    gnt_id    = 1'b0;
`endif
  end

  assign sel_addr  = gnt_id ? r1_addr : r0_addr;
  assign last_beat = is_write ? (beat == 2'd1) : (beat == 2'd3);

`ifdef SRAM_ARB_IFETCH_PORT_EN
  assign unused_bits = ^{r0_addr[31:19], r0_addr[1:0], r1_addr[31:19], r1_addr[2:0]};
`else
  assign unused_bits = ^{r0_addr[31:19], r0_addr[1:0], r1_addr[31:19], r1_addr[2:0],
                         r1_req, prefer};
`endif

  // Arbiter FSM with all SRAM pins and requester outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prefer    <= 1'b0;
      is_write  <= 1'b0;
      beat      <= 2'd0;
      cyc       <= '0;
      line_buf  <= 48'd0;
      wdata_hi  <= 16'd0;
      dq_out    <= 16'd0;
      dq_oe     <= 1'b0;
      busy      <= 1'b0;
      owner     <= 1'b0;
      r0_ready  <= 1'b0;
      r1_ready  <= 1'b0;
      r0_rdata  <= 64'd0;
      r1_rdata  <= 64'd0;
      SRAM_ADDR <= 18'd0;
      SRAM_WE_N <= 1'b1;
    end else begin
      r0_ready <= 1'b0;
      r1_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            state    <= ACCESS;
            busy     <= 1'b1;
            owner    <= gnt_id;
            prefer   <= ~gnt_id;
            beat     <= 2'd0;
            cyc      <= '0;
            is_write <= ~gnt_id & r0_we;
            if (~gnt_id & r0_we) begin
              // Word write: two halfwords at an even halfword address.
              SRAM_ADDR <= {r0_addr[18:2], 1'b0};
              dq_out    <= r0_wdata[15:0];
              wdata_hi  <= r0_wdata[31:16];
              dq_oe     <= 1'b1;
              SRAM_WE_N <= 1'b0;
            end else begin
              // Line read: four halfwords from a 4-aligned halfword address.
              SRAM_ADDR <= {sel_addr[18:3], 2'b00};
            end
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          if (cyc == CW'(WAIT_CYCLES)) begin
            cyc <= '0;
            if (last_beat) begin
              state     <= DONE;
              dq_oe     <= 1'b0;
              SRAM_WE_N <= 1'b1;
              if (owner) begin
                r1_ready <= 1'b1;
              end else begin
                r0_ready <= 1'b1;
              end
              if (!is_write) begin
                // Last halfword arrives on this edge, straight into the line.
                if (owner) begin
                  r1_rdata <= {SRAM_DQ, line_buf};
                end else begin
                  r0_rdata <= {SRAM_DQ, line_buf};
                end
              end
            end else begin
              beat      <= beat + 2'd1;
              SRAM_ADDR <= SRAM_ADDR + 18'd1;
              dq_out    <= wdata_hi;
              line_buf  <= {SRAM_DQ, line_buf[47:16]};
            end
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: two instances (WAIT_CYCLES=1 and 3), each with
// a behavioural SRAM. Expected lines, memory contents, grant order and timing
// come from a transaction-level reference model held in this bench.
module tb_sram_arbiter;

  localparam int W0 = 1;
  localparam int W1 = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [2];
  logic        r0_req   [2];
  logic        r0_we    [2];
  logic [31:0] r0_addr  [2];
  logic [31:0] r0_wdata [2];
  logic        r1_req   [2];
  logic [31:0] r1_addr  [2];
  logic [63:0] r0_rdata [2];
  logic [63:0] r1_rdata [2];
  logic        r0_ready [2];
  logic        r1_ready [2];
  logic        busy     [2];
  logic        owner    [2];
  logic [17:0] sa       [2];
  logic        ub_n [2], lb_n [2], we_n [2], ce_n [2], oe_n [2];
  wire  [15:0] dq0, dq1;

  logic [15:0] mem0 [4096];
  logic [15:0] mem1 [4096];
  logic [15:0] ref_mem [2][4096];
  logic [63:0] exp_rd [2][2];
  logic        tie_next [2];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = 12'd0;

  int checks = 0;
  int failures = 0;

  sram_arbiter #(.WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .rst(rst[0]),
    .r0_req(r0_req[0]), .r0_we(r0_we[0]), .r0_addr(r0_addr[0]), .r0_wdata(r0_wdata[0]),
    .r0_rdata(r0_rdata[0]), .r0_ready(r0_ready[0]),
    .r1_req(r1_req[0]), .r1_addr(r1_addr[0]), .r1_rdata(r1_rdata[0]), .r1_ready(r1_ready[0]),
    .busy(busy[0]), .owner(owner[0]),
    .SRAM_DQ(dq0), .SRAM_ADDR(sa[0]), .SRAM_UB_N(ub_n[0]), .SRAM_LB_N(lb_n[0]),
    .SRAM_WE_N(we_n[0]), .SRAM_CE_N(ce_n[0]), .SRAM_OE_N(oe_n[0])
  );

  sram_arbiter #(.WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .rst(rst[1]),
    .r0_req(r0_req[1]), .r0_we(r0_we[1]), .r0_addr(r0_addr[1]), .r0_wdata(r0_wdata[1]),
    .r0_rdata(r0_rdata[1]), .r0_ready(r0_ready[1]),
    .r1_req(r1_req[1]), .r1_addr(r1_addr[1]), .r1_rdata(r1_rdata[1]), .r1_ready(r1_ready[1]),
    .busy(busy[1]), .owner(owner[1]),
    .SRAM_DQ(dq1), .SRAM_ADDR(sa[1]), .SRAM_UB_N(ub_n[1]), .SRAM_LB_N(lb_n[1]),
    .SRAM_WE_N(we_n[1]), .SRAM_CE_N(ce_n[1]), .SRAM_OE_N(oe_n[1])
  );

  // Asynchronous SRAM: drives read data whenever not being written.
  assign dq0 = (we_n[0] === 1'b1) ? mem0[sa[0][11:0]] : 16'hzzzz;
  assign dq1 = (we_n[1] === 1'b1) ? mem1[sa[1][11:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (we_n[0] === 1'b0) mem0[sa[0][11:0]] <= dq0;
    else if (pl_en) mem0[pl_addr] <= ref_mem[0][pl_addr];
    if (we_n[1] === 1'b0) mem1[sa[1][11:0]] <= dq1;
    else if (pl_en) mem1[pl_addr] <= ref_mem[1][pl_addr];
  end

  function automatic logic [15:0] dq_of(input int d);
    return (d != 0) ? dq1 : dq0;
  endfunction

  function automatic logic [15:0] mem_of(input int d, input int i);
    return (d != 0) ? mem1[i] : mem0[i];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input int d, input bit p, input bit we, input logic [31:0] a,
                       input logic [31:0] wd);
    if (!p) begin
      r0_req[d] = 1'b1; r0_we[d] = we; r0_addr[d] = a; r0_wdata[d] = wd;
    end else begin
      r1_req[d] = 1'b1; r1_addr[d] = a;
    end
  endtask

  // Follow one transaction granted on the next rising edge through to its
  // ready pulse and the idle cycle after it.
  task automatic finish(input int d, input bit p, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input string tag);
    int          wc;
    int          lat;
    int          j;
    int          bad;
    int          idx;
    bit          rdy;
    logic [17:0] base;
    logic [11:0] b;
    wc   = (d != 0) ? W1 : W0;
    lat  = (we ? 2 : 4) * (wc + 1);
    j    = 0;
    bad  = 0;
    rdy  = 1'b0;
    base = we ? {a[18:2], 1'b0} : {a[18:3], 2'b00};
    b    = base[11:0];
    while (!rdy && j < 200) begin
      @(negedge clk);
      j++;
      rdy = p ? r1_ready[d] : r0_ready[d];
      if (!rdy && j <= lat) begin
        idx = (j - 1) / (wc + 1);
        if (sa[d] !== base + 18'(idx)) bad++;
        if (busy[d] !== 1'b1) bad++;
        if (we_n[d] !== ~we) bad++;
        if (we && dq_of(d) !== ((idx == 0) ? wd[15:0] : wd[31:16])) bad++;
      end
      if ((p ? r0_ready[d] : r1_ready[d]) !== 1'b0) bad++;
    end
    chk({tag, " latency"}, 64'(j - 1), 64'(lat));
    chk({tag, " beat_seq"}, 64'(bad), 64'd0);
    chk({tag, " owner"}, {63'd0, owner[d]}, {63'd0, p});
    chk({tag, " done_pins"}, {62'd0, busy[d], we_n[d]}, 64'd3);
    tie_next[d] = ~p;
    if (we) begin
      ref_mem[d][b]         = wd[15:0];
      ref_mem[d][b + 12'd1] = wd[31:16];
    end else begin
      exp_rd[d][p] = {ref_mem[d][b + 12'd3], ref_mem[d][b + 12'd2],
                      ref_mem[d][b + 12'd1], ref_mem[d][b]};
    end
    chk({tag, " r0_rdata"}, r0_rdata[d], exp_rd[d][0]);
    chk({tag, " r1_rdata"}, r1_rdata[d], exp_rd[d][1]);
    if (!p) r0_req[d] = 1'b0;
    else r1_req[d] = 1'b0;
    @(negedge clk);
    chk({tag, " pulse_end"}, {61'd0, r0_ready[d], r1_ready[d], busy[d]}, 64'd0);
  endtask

  initial begin
    bit          cw  [2];
    logic [31:0] ca  [2];
    logic [31:0] cwd [2];
    int          bad;
    bit          w;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; r0_req[d] = 1'b0; r0_we[d] = 1'b0; r0_addr[d] = 32'd0;
      r0_wdata[d] = 32'd0; r1_req[d] = 1'b0; r1_addr[d] = 32'd0;
      tie_next[d] = 1'b0;
      exp_rd[d][0] = 64'd0; exp_rd[d][1] = 64'd0;
      for (int i = 0; i < 4096; i++) ref_mem[d][i] = 16'($urandom());
    end
    ref_mem[0][12'h204] = 16'h1111; ref_mem[0][12'h205] = 16'h2222;
    ref_mem[0][12'h206] = 16'h3333; ref_mem[0][12'h207] = 16'h4444;

    // Preload both SRAMs while reset is held.
    @(negedge clk);
    pl_en = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      pl_addr = 12'(i);
      @(negedge clk);
    end
    pl_en = 1'b0;

    // Reset state.
    for (int d = 0; d < 2; d++) begin
      chk("rst_ctl", {59'd0, busy[d], owner[d], r0_ready[d], r1_ready[d], we_n[d]}, 64'd1);
      chk("rst_rdata", r0_rdata[d] | r1_rdata[d], 64'd0);
      chk("rst_addr", {46'd0, sa[d]}, 64'd0);
      chk("rst_ties", {60'd0, ce_n[d], oe_n[d], ub_n[d], lb_n[d]}, 64'd0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);

`ifdef SRAM_ARB_IFETCH_PORT_EN
    // Simultaneous requests after reset: r0 first, then r1, and again.
    for (int k = 0; k < 2; k++) begin
      start(1, 1'b0, 1'b0, 32'h0000_0100, 32'd0);
      start(1, 1'b1, 1'b0, 32'h0000_0240, 32'd0);
      finish(1, 1'b0, 1'b0, 32'h0000_0100, 32'd0, "tie_r0");
      finish(1, 1'b1, 1'b0, 32'h0000_0240, 32'd0, "tie_r1");
    end
    // WAIT_CYCLES=3 fetch: addresses 0x010..0x013 held four cycles each.
    start(1, 1'b1, 1'b0, 32'h0000_0020, 32'd0);
    finish(1, 1'b1, 1'b0, 32'h0000_0020, 32'd0, "w3_r1_read");
`else
    // r1 asserted alongside r0 must be ignored.
    start(1, 1'b0, 1'b0, 32'h0000_0100, 32'd0);
    start(1, 1'b1, 1'b0, 32'h0000_0240, 32'd0);
    finish(1, 1'b0, 1'b0, 32'h0000_0100, 32'd0, "solo_r0");
    r1_req[1] = 1'b0;
    start(1, 1'b0, 1'b0, 32'h0000_0020, 32'd0);
    finish(1, 1'b0, 1'b0, 32'h0000_0020, 32'd0, "w3_r0_read");
`endif

    // Line read from 0x408 and word write to 0x10.
    start(0, 1'b0, 1'b0, 32'h0000_0408, 32'd0);
    finish(0, 1'b0, 1'b0, 32'h0000_0408, 32'd0, "rd_408");
    chk("rd_408_const", r0_rdata[0], 64'h4444_3333_2222_1111);
    start(0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    finish(0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "wr_10");
    chk("wr_10_mem", {32'd0, mem0[9], mem0[8]}, 64'hDEAD_BEEF);
    chk("wr_10_rdata", r0_rdata[0], 64'h4444_3333_2222_1111);

    // Random traffic; upper address bits are noise the arbiter must ignore.
    for (int n = 0; n < 24; n++) begin
      int mode;
      for (int p = 0; p < 2; p++) begin
        ca[p]  = $urandom() & 32'hFFF8_1FFF;
        cwd[p] = $urandom();
        cw[p]  = (p == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
`ifdef SRAM_ARB_IFETCH_PORT_EN
      mode = $urandom_range(0, 2);
      if (mode == 2) begin
        w = tie_next[0];
        start(0, 1'b0, cw[0], ca[0], cwd[0]);
        start(0, 1'b1, 1'b0, ca[1], 32'd0);
        finish(0, w, cw[w], ca[w], cwd[w], "rnd_tie_a");
        finish(0, ~w, cw[~w], ca[~w], cwd[~w], "rnd_tie_b");
      end else begin
        w = 1'(mode);
        start(0, w, cw[w], ca[w], cwd[w]);
        finish(0, w, cw[w], ca[w], cwd[w], "rnd_single");
      end
`else
      mode = $urandom_range(0, 1);
      start(0, 1'b0, cw[0], ca[0], cwd[0]);
      if (mode == 1) start(0, 1'b1, 1'b0, ca[1], 32'd0);
      finish(0, 1'b0, cw[0], ca[0], cwd[0], "rnd_r0");
      r1_req[0] = 1'b0;
`endif
    end

    // Reset in the third ACCESS cycle of a read aborts it silently.
    start(0, 1'b0, 1'b0, 32'h0000_0408, 32'd0);
    repeat (3) @(negedge clk);
    rst[0] = 1'b1; r0_req[0] = 1'b0;
    @(negedge clk);
    chk("abort_ctl", {60'd0, busy[0], owner[0], r0_ready[0], r1_ready[0]}, 64'd0);
    chk("abort_rdata", r0_rdata[0] | r1_rdata[0], 64'd0);
    chk("abort_pins", {45'd0, sa[0], we_n[0]}, 64'd1);
    exp_rd[0][0] = 64'd0; exp_rd[0][1] = 64'd0; tie_next[0] = 1'b0;
    rst[0] = 1'b0;
    @(negedge clk);

`ifdef SRAM_ARB_IFETCH_PORT_EN
    start(0, 1'b1, 1'b0, 32'h0000_0808, 32'd0);
    finish(0, 1'b1, 1'b0, 32'h0000_0808, 32'd0, "post_abort_r1");
`else
    // Held r1 request alone must never be served.
    bad = 0;
    r1_req[0] = 1'b1; r1_addr[0] = 32'h0000_0808;
    repeat (30) begin
      @(negedge clk);
      if (r1_ready[0] !== 1'b0 || sa[0] !== 18'd0 || busy[0] !== 1'b0) bad++;
    end
    r1_req[0] = 1'b0;
    chk("r1_ignored", 64'(bad), 64'd0);
    start(0, 1'b0, 1'b0, 32'h0000_0808, 32'd0);
    finish(0, 1'b0, 1'b0, 32'h0000_0808, 32'd0, "post_abort_r0");
`endif

    // SRAM contents against the reference memory.
    for (int d = 0; d < 2; d++) begin
      bad = 0;
      for (int i = 0; i < 4096; i++) begin
        if (mem_of(d, i) !== ref_mem[d][i]) bad++;
      end
      chk("sram_contents", 64'(bad), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, meaning extra hold cycles per 16-bit SRAM beat (beat length = WAIT_CYCLES+1 cycles).
REQ-002 SHALL have port clk  in  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  in  1  reset: synchronous, active-high.
REQ-004 SHALL have ports r0_req in 1, r0_we in 1, r0_addr in 32, r0_wdata in 32: data-cache requester (read line / write word), byte address.
REQ-005 SHALL have ports r0_rdata out 64, r0_ready out 1: data-cache read line, completion pulse.
REQ-006 SHALL have ports r1_req in 1, r1_addr in 32: instruction-fetch requester, read-only.
REQ-007 SHALL have ports r1_rdata out 64, r1_ready out 1: fetch line, completion pulse.
REQ-008 SHALL have ports busy out 1 (FSM not IDLE) and owner out 1 (0 = r0, 1 = r1; current or last grant).
REQ-009 SHALL have ports SRAM_DQ inout 16, SRAM_ADDR out 18, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N out 1 each.

Function
REQ-010 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE; no other states.
REQ-011 SHALL sample requests only in IDLE; a req high at edge k starts ACCESS at edge k for the granted requester.
REQ-012 SHALL arbitrate round-robin: single requester granted directly; both high -> grant the one not granted last; after reset r0 wins first tie.
REQ-013 Requester SHALL hold req, we, addr, wdata stable until its ready pulse; arbiter latches addr/wdata/we at grant and ignores later changes.
REQ-014 Read SHALL fetch 4 halfwords from SRAM_ADDR base {addr[18:3],2'b00}, ascending; halfword i fills rdata[16i+15:16i]; addr[2:0] ignored.
REQ-015 Write (r0_we=1) SHALL store 2 halfwords at base {addr[18:2],1'b0}: wdata[15:0] then wdata[31:16]; addr[1:0] ignored.
REQ-016 Each beat SHALL hold SRAM_ADDR for WAIT_CYCLES+1 cycles; read data captured on the last edge of the beat.
REQ-017 Write beats SHALL drive SRAM_DQ and SRAM_WE_N=0 for the whole beat; all other times SRAM_DQ=Z, SRAM_WE_N=1.
REQ-018 SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N SHALL be constant 0.
REQ-019 ACCESS SHALL last N*(WAIT_CYCLES+1) cycles (N=4 read, 2 write), then enter DONE.
REQ-020 In DONE the granted requester's ready SHALL be 1 for exactly one cycle; the other ready stays 0.
REQ-021 rdata of the granted requester SHALL update at entry to DONE and hold until its next read completion; writes do not alter r0_rdata.
REQ-022 Req still high during or after DONE SHALL be treated as a new request at the following IDLE cycle (minimum one IDLE cycle between transactions).
REQ-023 Latency SHALL be: WAIT_CYCLES=1 read -> ready 8 cycles after sampling edge; write -> 4 cycles.
REQ-024 SRAM_ADDR in IDLE SHALL hold its last value (0 after reset).

Reset
REQ-025 rst SHALL force IDLE, busy=0, owner=0, r0_ready=r1_ready=0, r0_rdata=r1_rdata=0, SRAM_ADDR=0, SRAM_WE_N=1, SRAM_DQ=Z, tie pointer to r0.
REQ-026 rst during ACCESS or DONE SHALL abort without ready pulse; partial write may remain in SRAM; rst has priority over all requests.

Configuration
REQ-027 Macro SRAM_ARB_IFETCH_PORT_EN defined: r1 port and round-robin active as above.
REQ-028 Macro undefined: r1_req ignored, r1_ready=0, r1_rdata=0, owner=0, r0 granted whenever requesting; r0 timing unchanged.

Verification
REQ-029 Reset, r0 read addr 0x0000_0408, SRAM halfwords 0x204..0x207 = 1111,2222,3333,4444 -> r0_ready 8 cycles later, r0_rdata=0x4444_3333_2222_1111.
REQ-030 r0 write addr 0x0000_0010, wdata 0xDEAD_BEEF -> SRAM[0x008]=0xBEEF, SRAM[0x009]=0xDEAD, WE_N low 4 cycles, r0_ready after 4 cycles, r0_rdata unchanged.
REQ-031 r0_req and r1_req high same edge after reset -> r0 served first, r1 next (owner 0 then 1); repeated tie alternates.
REQ-032 WAIT_CYCLES=3, r1 read addr 0x20 -> each SRAM_ADDR 0x010..0x013 held 4 cycles, r1_ready 16 cycles after sampling.
REQ-033 rst asserted mid-read (cycle 3 of ACCESS) -> no ready pulse, busy=0, rdata=0 next cycle, next r1-only request served normally.
REQ-034 Without SRAM_ARB_IFETCH_PORT_EN, r1_req held high with r0 idle -> r1_ready never asserts, SRAM_ADDR stays 0.
